// File: rtl/fft_buf_scheduler_if.sv
// rtl/fft_buf_scheduler_if.sv - sample, engine, result and RAM port bundle for fft_buf_scheduler
interface fft_buf_scheduler_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              fft_start;
  logic              fft_done;
  logic              fft_ce;
  logic              fft_wre;
  logic [ADDR_W-1:0] fft_ad;
  logic [DATA_W-1:0] fft_din;
  logic [DATA_W-1:0] fft_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_reset;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        state;

  // Environment side: sample source, FFT engine, downstream sink and RAM
  modport master (
    output enable, in_valid, in_data, fft_done, fft_ce, fft_wre, fft_ad, fft_din,
           out_ready, ram_dout,
    input  in_ready, fft_start, fft_dout, out_valid, out_data, out_last,
           ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din, state
  );

  // Scheduler side
  modport slave (
    input  enable, in_valid, in_data, fft_done, fft_ce, fft_wre, fft_ad, fft_din,
           out_ready, ram_dout,
    output in_ready, fft_start, fft_dout, out_valid, out_data, out_last,
           ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din, state
  );
endinterface

// File: rtl/fft_buf_scheduler.sv
// rtl/fft_buf_scheduler.sv - LOAD/COMPUTE/UNLOAD owner of the single-port FFT buffer (option macro: FFT_BITREV_LOAD_EN)
module fft_buf_scheduler #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int N      = 2048
) (
  input logic                clk,
  input logic                reset,
  fft_buf_scheduler_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_N   = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_NM1 = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  r_rcnt;
  logic              r_start;
  logic              r_inflight;
  logic              r_infl_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_load_done;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic              w_unload_done;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_load_ad;

  assign w_in_ready    = (r_state == S_LOAD) && (r_wcnt < C_N);
  assign w_in_hs       = bus.in_valid && w_in_ready;
  assign w_load_done   = w_in_hs && (r_wcnt == C_NM1);
  assign w_push        = r_inflight;
  assign w_pop         = (r_count != 2'd0) && bus.out_ready;
  assign w_head_last   = r_fifo_last[r_rd_ptr];
  assign w_unload_done = (r_state == S_UNLOAD) && w_pop && w_head_last;
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight};
  // A pop this cycle frees a FIFO slot, so the credit check counts it; without
  // that the read pipeline would bubble every other word with out_ready high.
  assign w_issue       = (r_state == S_UNLOAD) && (r_rcnt < C_N) &&
                         ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

`ifdef FFT_BITREV_LOAD_EN
  localparam int LOG2N = $clog2(N);
  // Bit-reversed write address so the in-place DIT engine sees reordered input
  always_comb begin
    w_load_ad = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_load_ad[i] = r_wcnt[LOG2N-1-i];
    end
  end
`else
  assign w_load_ad = r_wcnt[ADDR_W-1:0];
`endif

  // Phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase sequencing; fft_done only counts in COMPUTE and not alongside fft_start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.enable) w_next = S_LOAD;
      S_LOAD:    if (w_load_done) w_next = S_COMPUTE;
      S_COMPUTE: if (bus.fft_done && !r_start) w_next = S_UNLOAD;
      S_UNLOAD:  if (w_unload_done) w_next = bus.enable ? S_LOAD : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // RAM port ownership: sample writes, engine pass-through, or result reads
  always_comb begin
    bus.ram_ce  = 1'b0;
    bus.ram_wre = 1'b0;
    bus.ram_ad  = '0;
    bus.ram_din = '0;
    case (r_state)
      S_LOAD: begin
        if (w_in_hs) begin
          bus.ram_ce  = 1'b1;
          bus.ram_wre = 1'b1;
          bus.ram_ad  = w_load_ad;
          bus.ram_din = bus.in_data;
        end
      end
      S_COMPUTE: begin
        bus.ram_ce  = bus.fft_ce;
        bus.ram_wre = bus.fft_wre;
        bus.ram_ad  = bus.fft_ad;
        bus.ram_din = bus.fft_din;
      end
      S_UNLOAD: begin
        bus.ram_ce = w_issue;
        bus.ram_ad = r_rcnt[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // Counters, start pulse, read pipeline and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_start     <= 1'b0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_fifo_last <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_start    <= w_load_done;
      r_inflight <= w_issue;
      if (w_load_done) begin
        r_wcnt <= '0;
      end else if (w_in_hs) begin
        r_wcnt <= r_wcnt + CNT_W'(1);
      end
      if (w_unload_done) begin
        r_rcnt <= '0;
      end else if (w_issue) begin
        r_rcnt <= r_rcnt + CNT_W'(1);
      end
      if (w_issue) begin
        r_infl_last <= (r_rcnt == C_NM1);
      end
      if (w_push) begin
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // FIFO payload captures RAM read data the cycle after issue
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.ram_dout;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.fft_start = r_start;
  assign bus.fft_dout  = bus.ram_dout;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_last  = (r_count != 2'd0) && w_head_last;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = reset;
  assign bus.state     = r_state;
endmodule

// File: tb/tb_fft_buf_scheduler.sv
// tb/tb_fft_buf_scheduler.sv - self-checking bench for fft_buf_scheduler with N=8
module tb_fft_buf_scheduler;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_buf_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fft_buf_scheduler #(.ADDR_W(AW), .DATA_W(DW), .N(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [DW-1:0] data; logic [AW-1:0] ad; } load_vec_t;
  typedef struct { logic ce; logic wre; logic [AW-1:0] ad; logic [DW-1:0] din; logic done; } comp_vec_t;
  typedef struct { logic [AW-1:0] ad; logic [DW-1:0] din; } wr_t;
  typedef struct { logic [DW-1:0] data; logic last; } ow_t;

  load_vec_t load_tbl [NP];
  comp_vec_t comp_tbl [4];
  wr_t       wq [$];
  ow_t       oq [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram_mem [0:2047];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] exp_mem [0:2047];

  // Behavioural single-port RAM: registered read one cycle after ce
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) ram_mem[bus.ram_ad] <= bus.ram_din;
      else             ram_q <= ram_mem[bus.ram_ad];
    end
  end
  assign bus.ram_dout = ram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard for LOAD
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!reset && bus.state == 2'd1 && bus.ram_ce) begin
        if (wq.size() == 0) begin
          check("unexpected_load_write", 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          check("load_ad", 32'(bus.ram_ad), 32'(w.ad));
          check("load_din", bus.ram_din, w.din);
          check("load_wre", 32'(bus.ram_wre), 32'd1);
        end
      end
    end
  end

  // Output scoreboard, stall stability and outstanding-read bound
  initial begin
    ow_t o;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    int issued;
    int popped;
    prev_stall = 1'b0; prev_data = '0; issued = 0; popped = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0; issued = 0; popped = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (oq.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            o = oq.pop_front();
            check("out_data", bus.out_data, o.data);
            check("out_last", 32'(bus.out_last), 32'(o.last));
          end
          popped++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.state == 2'd3) begin
          if (bus.ram_ce && !bus.ram_wre) issued++;
          check("outstanding_le_2", 32'(issued - popped <= 2), 32'd1);
        end else begin
          issued = 0; popped = 0;
        end
      end
    end
  end

  task automatic do_load(input logic [DW-1:0] base, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + load_tbl[i].data;
      bus.fft_done = (i == 2);
      w.ad  = load_tbl[i].ad;
      w.din = bus.in_data;
      wq.push_back(w);
      exp_mem[w.ad] = w.din;
      @(negedge clk);
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      check("load_state", 32'(bus.state), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.fft_done = 1'b0;
  endtask

  task automatic do_compute(input bit use_tbl);
    comp_vec_t row;
    for (int k = 0; k < 4; k++) begin
      if (use_tbl) begin
        row = comp_tbl[k];
      end else begin
        row.ce = 1'b0; row.wre = 1'b0; row.ad = '0; row.din = '0; row.done = (k == 0);
      end
      bus.fft_ce = row.ce; bus.fft_wre = row.wre; bus.fft_ad = row.ad;
      bus.fft_din = row.din; bus.fft_done = row.done;
      if (row.ce && row.wre) exp_mem[row.ad] = row.din;
      @(negedge clk);
      check("comp_state", 32'(bus.state), 32'd2);
      check("fft_start", 32'(bus.fft_start), 32'(k == 0));
      check("comp_ram_ce", 32'(bus.ram_ce), 32'(row.ce));
      check("comp_ram_wre", 32'(bus.ram_wre), 32'(row.wre));
      check("comp_ram_ad", 32'(bus.ram_ad), 32'(row.ad));
      check("comp_ram_din", bus.ram_din, row.din);
      check("comp_fft_dout", bus.fft_dout, bus.ram_dout);
      check("comp_in_ready", 32'(bus.in_ready), 32'd0);
      check("comp_out_valid", 32'(bus.out_valid), 32'd0);
      check("comp_ram_reset", 32'(bus.ram_reset), 32'd0);
      @(posedge clk); #1;
    end
    bus.fft_ce = 1'b0; bus.fft_wre = 1'b0; bus.fft_ad = '0; bus.fft_din = '0;
    bus.fft_done = 1'b1;
    @(posedge clk); #1;
    bus.fft_done = 1'b0;
  endtask

  // mode 0: out_ready held high, mode 1: out_ready 1,0,0 repeating
  task automatic do_unload(input int mode, input bit en_after, input int abort_at);
    ow_t o;
    bit  aborted;
    aborted = 1'b0;
    for (int i = 0; i < NP; i++) begin
      o.data = exp_mem[i];
      o.last = (i == NP - 1);
      oq.push_back(o);
    end
    bus.enable = en_after;
    for (int k = 0; k < 60; k++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      @(negedge clk);
      if (k == 0) check("unload_state", 32'(bus.state), 32'd3);
      if (k < 2) check("first_valid_latency", 32'(bus.out_valid), 32'd0);
      if (k == 2) check("first_valid", 32'(bus.out_valid), 32'd1);
      if (mode == 0 && k >= 2 && k < 2 + NP) check("unload_rate", 32'(bus.out_valid), 32'd1);
      #1;
      if (abort_at > 0 && (NP - oq.size()) >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (oq.size() == 0) break;
      @(posedge clk); #1;
    end
    if (aborted) begin
      @(posedge clk); #1;
      reset = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_unload_state", 32'(bus.state), 32'd0);
      check("abort_unload_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_unload_ram_ce", 32'(bus.ram_ce), 32'd0);
      check("abort_unload_in_ready", 32'(bus.in_ready), 32'd0);
      oq.delete();
    end else begin
      check("unload_drained", 32'(oq.size()), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("unload_exit_state", 32'(bus.state), en_after ? 32'd1 : 32'd0);
      check("after_unload_ram_ce", 32'(bus.ram_ce), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] brev [NP];
    brev = '{11'd0, 11'd4, 11'd2, 11'd6, 11'd1, 11'd5, 11'd3, 11'd7};
    for (int i = 0; i < NP; i++) begin
      load_tbl[i].data = DW'(i);
`ifdef FFT_BITREV_LOAD_EN
      load_tbl[i].ad = brev[i];
`else
      load_tbl[i].ad = AW'(i);
`endif
    end
    comp_tbl[0] = '{1'b1, 1'b1, 11'd5,     32'h0001_0002, 1'b1};
    comp_tbl[1] = '{1'b1, 1'b0, 11'd5,     32'h0000_0000, 1'b0};
    comp_tbl[2] = '{1'b0, 1'b0, 11'h7ff,   32'hdead_beef, 1'b0};
    comp_tbl[3] = '{1'b1, 1'b0, 11'd3,     32'h1234_5678, 1'b0};

    reset = 1'b1;
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.fft_done = 1'b0;
    bus.fft_ce = 1'b0; bus.fft_wre = 1'b0; bus.fft_ad = '0; bus.fft_din = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_fft_start", 32'(bus.fft_start), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_ram_ce", 32'(bus.ram_ce), 32'd0);
    check("rst_ram_wre", 32'(bus.ram_wre), 32'd0);
    check("rst_ram_ad", 32'(bus.ram_ad), 32'd0);
    check("rst_ram_din", bus.ram_din, 32'd0);
    check("rst_ram_oce", 32'(bus.ram_oce), 32'd1);
    check("rst_ram_reset", 32'(bus.ram_reset), 32'd1);

    @(posedge clk); #1;
    reset = 1'b0; bus.enable = 1'b1;
    @(posedge clk); #1;

    // Frame 1: data 0..7, engine table, unload at full rate, back to LOAD
    do_load(32'h0, NP);
    do_compute(1'b1);
    do_unload(0, 1'b1, 0);

    // Frame 2: reset after three samples
    do_load(32'h100, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_load_state", 32'(bus.state), 32'd0);
    check("abort_load_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_load_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_load_ram_ce", 32'(bus.ram_ce), 32'd0);
    check("abort_load_wq_empty", 32'(wq.size()), 32'd0);
    @(posedge clk); #1;

    // Frame 3: clean frame from address 0, throttled unload, then IDLE
    do_load(32'h200, NP);
    do_compute(1'b0);
    do_unload(1, 1'b0, 0);
    @(negedge clk);
    check("idle_hold_state", 32'(bus.state), 32'd0);
    bus.enable = 1'b1;
    @(posedge clk); #1;

    // Frame 4: reset after three results
    do_load(32'h300, NP);
    do_compute(1'b0);
    do_unload(0, 1'b1, 3);

    // Frame 5: runs cleanly after the aborted unload
    do_load(32'h400, NP);
    do_compute(1'b0);
    do_unload(0, 1'b0, 0);

    check("final_wq_empty", 32'(wq.size()), 32'd0);
    check("final_oq_empty", 32'(oq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
